instr_dcd_burst: RTL and testbench

Parametrised SPI-side instruction decoder that turns the byte stream from the SPI slave into register-file read/write strobes. It handles registers of DATA_W bits, transferred as DATA_W/8 bytes MSB-first, and adds a burst mode with address auto-increment and frame abort on chip-select release. It sits between the SPI slave interface and the peripheral register bank, in the same position as the single-byte decoder it supersedes.

---
 rtl/instr_dcd_burst_if.sv | 26 ++
 rtl/instr_dcd_burst.sv | 136 +++++++++++++
 tb/tb_instr_dcd_burst.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_dcd_burst_if.sv
// SPI-side byte stream and register-bank strobe bundle for the burst instruction decoder.
// slave = decoder side, master = SPI slave / register bank (or bench) side.
interface instr_dcd_burst_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              cs_n;
  logic              byte_sync;
  logic [7:0]        data_in;
  logic [7:0]        data_out;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_read;
  logic [DATA_W-1:0] data_write;

  modport slave (
    input  cs_n, byte_sync, data_in, data_read,
    output data_out, read, write, addr, data_write
  );

  modport master (
    output cs_n, byte_sync, data_in, data_read,
    input  data_out, read, write, addr, data_write
  );
endinterface

// File: rtl/instr_dcd_burst.sv
// SPI instruction decoder: command byte then DATA_W/8 data bytes MSB-first, optional burst auto-increment.
// Strobes one cycle after the deciding byte_sync; no backpressure, byte_sync assumed >= 3 cycles apart.
module instr_dcd_burst #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_dcd_burst_if.slave      bus
);
  localparam int NB = DATA_W / 8;

  localparam logic [1:0] ST_CMD   = 2'd0;
  localparam logic [1:0] ST_WDATA = 2'd1;
  localparam logic [1:0] ST_RDATA = 2'd2;

  logic [1:0]        state_q,  state_d;
  logic [2:0]        idx_q,    idx_d;
  logic              burst_q,  burst_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic              read_q,   read_d;
  logic              write_q,  write_d;
  logic              refill_q, refill_d;
  logic [DATA_W-1:0] wsh_q,    wsh_d;
  logic [DATA_W-1:0] rsh_q,    rsh_d;
  logic [DATA_W-1:0] dw_q,     dw_d;

  logic last_byte;
  assign last_byte = (idx_q == 3'(NB - 1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    burst_d  = burst_q;
    addr_d   = addr_q;
    read_d   = 1'b0;
    write_d  = 1'b0;
    refill_d = 1'b0;
    wsh_d    = wsh_q;
    rsh_d    = rsh_q;
    dw_d     = dw_q;

    if (read_q) begin
      rsh_d = bus.data_read;
    end
    if (write_q && burst_q) begin
      addr_d = addr_q + ADDR_W'(1);
    end
    // Burst read refill: strobe and new address one cycle after the word's last byte.
    if (refill_q) begin
      read_d = 1'b1;
      addr_d = addr_q + ADDR_W'(1);
    end

    if (bus.cs_n) begin
      // Frame released: drop any partial word and pending refill, keep addr.
      state_d = ST_CMD;
      idx_d   = 3'd0;
      read_d  = 1'b0;
    end else if (bus.byte_sync) begin
      case (state_q)
        ST_CMD: begin
          burst_d = bus.data_in[6];
          addr_d  = bus.data_in[ADDR_W-1:0];
          idx_d   = 3'd0;
          wsh_d   = '0;
          rsh_d   = '0;
          if (bus.data_in[7]) begin
            state_d = ST_WDATA;
          end else begin
            state_d = ST_RDATA;
            read_d  = 1'b1;
          end
        end
        ST_WDATA: begin
          wsh_d = (wsh_q << 8) | DATA_W'(bus.data_in);
          if (last_byte) begin
            idx_d   = 3'd0;
            dw_d    = wsh_d;
            write_d = 1'b1;
            if (!burst_q) state_d = ST_CMD;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        ST_RDATA: begin
          rsh_d = rsh_q << 8;
          if (last_byte) begin
            idx_d = 3'd0;
            if (burst_q) refill_d = 1'b1;
            else         state_d  = ST_CMD;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        default: begin
          state_d = ST_CMD;
          idx_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_CMD;
      idx_q    <= 3'd0;
      burst_q  <= 1'b0;
      addr_q   <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      refill_q <= 1'b0;
      wsh_q    <= '0;
      rsh_q    <= '0;
      dw_q     <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      burst_q  <= burst_d;
      addr_q   <= addr_d;
      read_q   <= read_d;
      write_q  <= write_d;
      refill_q <= refill_d;
      wsh_q    <= wsh_d;
      rsh_q    <= rsh_d;
      dw_q     <= dw_d;
    end
  end

  assign bus.read       = read_q;
  assign bus.write      = write_q;
  assign bus.addr       = addr_q;
  assign bus.data_write = dw_q;
  assign bus.data_out   = (state_q == ST_RDATA) ? rsh_q[DATA_W-1 -: 8] : 8'h00;

endmodule

// File: tb/tb_instr_dcd_burst.sv
// Bench for instr_dcd_burst: directed scenarios plus random frames against a frame-level model.
module tb_instr_dcd_burst;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_dcd_burst_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  instr_dcd_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [15:0] regs [64];
  assign bus.data_read = regs[bus.addr];

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0]  rd_q[$];
  logic [21:0] wr_q[$];
  logic [7:0]  dout_q[$];
  logic [5:0]  exp_rd[$];
  logic [21:0] exp_wr[$];
  logic [7:0]  exp_dout[$];
  logic [7:0]  fb[$];

  logic       last_rd1, last_rd2;
  logic [7:0] last_d1, last_d2;
  logic [5:0] last_a2;
  logic       rd_prev = 1'b0;
  logic       wr_prev = 1'b0;

  // Strobe monitor: record every pulse, enforce one-cycle width and read/write exclusion.
  always @(negedge clk) begin
    if (bus.read) begin
      n_checks++;
      if (rd_prev || bus.write) begin
        n_fail++;
        $display("FAIL read_pulse: prev_read=%b write=%b, required both 0", rd_prev, bus.write);
      end
      rd_q.push_back(bus.addr);
    end
    if (bus.write) begin
      n_checks++;
      if (wr_prev) begin
        n_fail++;
        $display("FAIL write_pulse: prev_write=%b, required 0", wr_prev);
      end
      wr_q.push_back({bus.addr, bus.data_write});
    end
    rd_prev = bus.read;
    wr_prev = bus.write;
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.byte_sync = 1'b1;
    bus.data_in   = b;
    @(posedge clk); #1;
    bus.byte_sync = 1'b0;
    last_rd1 = bus.read;
    last_d1  = bus.data_out;
    @(posedge clk); #1;
    last_rd2 = bus.read;
    last_d2  = bus.data_out;
    last_a2  = bus.addr;
    repeat (2) @(posedge clk);
    #1;
    dout_q.push_back(bus.data_out);
  endtask

  task automatic clear_q;
    rd_q.delete();
    wr_q.delete();
    dout_q.delete();
  endtask

  task automatic open_frame;
    @(negedge clk);
    bus.cs_n = 1'b0;
  endtask

  task automatic close_frame;
    @(negedge clk);
    bus.cs_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_frame;
    clear_q();
    open_frame();
    foreach (fb[i]) send_byte(fb[i]);
    close_frame();
  endtask

  // Frame-level model: words are pairs of data bytes, burst advances the address per word.
  task automatic build_model;
    logic [7:0] cmd;
    logic [5:0] a0;
    int nd, words, nw;
    exp_rd.delete();
    exp_wr.delete();
    exp_dout.delete();
    cmd   = fb[0];
    a0    = cmd[5:0];
    nd    = fb.size() - 1;
    words = nd / 2;
    if (cmd[7]) begin
      nw = cmd[6] ? words : ((words > 0) ? 1 : 0);
      for (int w = 0; w < nw; w++) exp_wr.push_back({6'(a0 + w), fb[1 + 2*w], fb[2 + 2*w]});
    end else begin
      exp_rd.push_back(a0);
      if (cmd[6]) for (int w = 1; w <= words; w++) exp_rd.push_back(6'(a0 + w));
    end
    for (int j = 0; j <= nd; j++) begin
      logic [15:0] word;
      logic [7:0]  d;
      word = regs[6'(a0 + j / 2)];
      d = (j % 2 == 0) ? word[15:8] : word[7:0];
      if (cmd[7] || (!cmd[6] && j >= 2)) d = 8'h00;
      exp_dout.push_back(d);
    end
  endtask

  task automatic test_reset;
    n_checks++; if (bus.read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b want 0", bus.read); end
    n_checks++; if (bus.write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b want 0", bus.write); end
    n_checks++; if (bus.addr !== 6'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bus.addr); end
    n_checks++; if (bus.data_write !== 16'h0) begin n_fail++; $display("FAIL reset_data_write: got %h want 0000", bus.data_write); end
    n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h want 00", bus.data_out); end
  endtask

  task automatic test_single_write;
    fb = {8'h85, 8'hAB, 8'hCD};
    run_frame();
    n_checks++; if (wr_q.size() !== 1) begin n_fail++; $display("FAIL sw_count: got %0d want 1", wr_q.size()); end
    else begin
      n_checks++; if (wr_q[0] !== {6'd5, 16'hABCD}) begin n_fail++; $display("FAIL sw_word: got %h want %h", wr_q[0], {6'd5, 16'hABCD}); end
    end
    n_checks++; if (rd_q.size() !== 0) begin n_fail++; $display("FAIL sw_no_read: got %0d reads want 0", rd_q.size()); end
  endtask

  task automatic test_single_read;
    regs[3] = 16'h1234;
    clear_q();
    open_frame();
    send_byte(8'h03);
    n_checks++; if (last_rd1 !== 1'b1) begin n_fail++; $display("FAIL sr_strobe: got %b want 1", last_rd1); end
    n_checks++; if (last_d1 !== 8'h00) begin n_fail++; $display("FAIL sr_pre_capture: got %h want 00", last_d1); end
    n_checks++; if (last_rd2 !== 1'b0 || last_d2 !== 8'h12) begin n_fail++; $display("FAIL sr_capture: read=%b dout=%h want 0/12", last_rd2, last_d2); end
    send_byte(8'h00);
    send_byte(8'h00);
    close_frame();
    n_checks++; if (dout_q.size() !== 3) begin n_fail++; $display("FAIL sr_dout_count: got %0d want 3", dout_q.size()); end
    else begin
      n_checks++; if ({dout_q[0], dout_q[1], dout_q[2]} !== 24'h123400) begin n_fail++; $display("FAIL sr_dout_seq: got %h%h%h want 123400", dout_q[0], dout_q[1], dout_q[2]); end
    end
    n_checks++; if (rd_q.size() !== 1 || rd_q[0] !== 6'd3) begin n_fail++; $display("FAIL sr_reads: got %0d reads want one at 3", rd_q.size()); end
  endtask

  task automatic test_burst_write_wrap;
    fb = {8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
    run_frame();
    n_checks++; if (wr_q.size() !== 2) begin n_fail++; $display("FAIL bw_count: got %0d want 2", wr_q.size()); end
    else begin
      n_checks++; if (wr_q[0] !== {6'd63, 16'h1122}) begin n_fail++; $display("FAIL bw_first: got %h want %h", wr_q[0], {6'd63, 16'h1122}); end
      n_checks++; if (wr_q[1] !== {6'd0, 16'h3344}) begin n_fail++; $display("FAIL bw_wrap: got %h want %h", wr_q[1], {6'd0, 16'h3344}); end
    end
    n_checks++; if (bus.addr !== 6'd1) begin n_fail++; $display("FAIL bw_addr_after: got %0d want 1", bus.addr); end
  endtask

  task automatic test_burst_read;
    regs[10] = 16'h1111;
    regs[11] = 16'h2222;
    clear_q();
    open_frame();
    send_byte(8'h4A);
    send_byte(8'h00);
    send_byte(8'h00);
    n_checks++; if (last_rd1 !== 1'b0 || last_d1 !== 8'h00) begin n_fail++; $display("FAIL br_gap: read=%b dout=%h want 0/00", last_rd1, last_d1); end
    n_checks++; if (last_rd2 !== 1'b1 || last_a2 !== 6'd11 || last_d2 !== 8'h00) begin n_fail++; $display("FAIL br_refill: read=%b addr=%0d dout=%h want 1/11/00", last_rd2, last_a2, last_d2); end
    send_byte(8'h00);
    close_frame();
    n_checks++; if (dout_q.size() !== 4) begin n_fail++; $display("FAIL br_dout_count: got %0d want 4", dout_q.size()); end
    else begin
      n_checks++; if ({dout_q[0], dout_q[1], dout_q[2], dout_q[3]} !== 32'h11112222) begin n_fail++; $display("FAIL br_dout_seq: got %h%h%h%h want 11112222", dout_q[0], dout_q[1], dout_q[2], dout_q[3]); end
    end
    n_checks++; if (rd_q.size() !== 2) begin n_fail++; $display("FAIL br_reads: got %0d want 2", rd_q.size()); end
    else begin
      n_checks++; if ({rd_q[0], rd_q[1]} !== {6'd10, 6'd11}) begin n_fail++; $display("FAIL br_read_addr: got %0d,%0d want 10,11", rd_q[0], rd_q[1]); end
    end
  endtask

  task automatic test_abort;
    fb = {8'h82, 8'h55};
    run_frame();
    n_checks++; if (wr_q.size() !== 0) begin n_fail++; $display("FAIL ab_no_write: got %0d writes want 0", wr_q.size()); end
    n_checks++; if (bus.addr !== 6'd2) begin n_fail++; $display("FAIL ab_addr_kept: got %0d want 2", bus.addr); end
    fb = {8'h82, 8'h01, 8'h02};
    run_frame();
    n_checks++; if (wr_q.size() !== 1 || wr_q[0] !== {6'd2, 16'h0102}) begin n_fail++; $display("FAIL ab_next_frame: got %0d writes first %h want 1 of %h", wr_q.size(), (wr_q.size() > 0) ? wr_q[0] : 22'h0, {6'd2, 16'h0102}); end
  endtask

  task automatic test_reset_mid_burst;
    regs[20] = 16'hBEEF;
    clear_q();
    open_frame();
    send_byte(8'h54);
    send_byte(8'h00);
    rst_n = 1'b0;
    #1;
    n_checks++; if ({bus.read, bus.write, bus.addr, bus.data_write, bus.data_out} !== 32'h0) begin n_fail++; $display("FAIL rst_mid_outputs: r=%b w=%b a=%0d dw=%h do=%h want all 0", bus.read, bus.write, bus.addr, bus.data_write, bus.data_out); end
    @(negedge clk);
    rst_n = 1'b1;
    fb = {8'h85, 8'hAB, 8'hCD};
    run_frame();
    n_checks++; if (wr_q.size() !== 1 || wr_q[0] !== {6'd5, 16'hABCD}) begin n_fail++; $display("FAIL rst_mid_next: got %0d writes want 1 of %h", wr_q.size(), {6'd5, 16'hABCD}); end
    n_checks++; if (rd_q.size() !== 0) begin n_fail++; $display("FAIL rst_mid_no_read: got %0d reads want 0", rd_q.size()); end
  endtask

  task automatic test_random;
    for (int f = 0; f < 30; f++) begin
      logic [7:0] cmd;
      int nd;
      for (int r = 0; r < 64; r++) regs[r] = 16'($urandom);
      cmd = 8'($urandom);
      nd  = cmd[6] ? $urandom_range(0, 5) : $urandom_range(0, 2);
      fb.delete();
      fb.push_back(cmd);
      for (int k = 0; k < nd; k++) fb.push_back(8'($urandom));
      build_model();
      run_frame();
      n_checks++;
      if (rd_q.size() !== exp_rd.size() || wr_q.size() !== exp_wr.size() || dout_q.size() !== exp_dout.size()) begin
        n_fail++;
        $display("FAIL rnd_counts cmd=%h: reads %0d/%0d writes %0d/%0d bytes %0d/%0d (got/want)",
                 cmd, rd_q.size(), exp_rd.size(), wr_q.size(), exp_wr.size(), dout_q.size(), exp_dout.size());
      end else begin
        foreach (exp_rd[i]) begin
          n_checks++; if (rd_q[i] !== exp_rd[i]) begin n_fail++; $display("FAIL rnd_read cmd=%h #%0d: got %0d want %0d", cmd, i, rd_q[i], exp_rd[i]); end
        end
        foreach (exp_wr[i]) begin
          n_checks++; if (wr_q[i] !== exp_wr[i]) begin n_fail++; $display("FAIL rnd_write cmd=%h #%0d: got %h want %h", cmd, i, wr_q[i], exp_wr[i]); end
        end
        foreach (exp_dout[i]) begin
          n_checks++; if (dout_q[i] !== exp_dout[i]) begin n_fail++; $display("FAIL rnd_dout cmd=%h byte %0d: got %h want %h", cmd, i, dout_q[i], exp_dout[i]); end
        end
      end
    end
  endtask

  initial begin
    bus.cs_n      = 1'b1;
    bus.byte_sync = 1'b0;
    bus.data_in   = 8'h00;
    for (int r = 0; r < 64; r++) regs[r] = 16'($urandom);
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    test_single_write();
    test_single_read();
    test_burst_write_wrap();
    test_burst_read();
    test_abort();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
